// File: rtl/cursor_ctrl.sv
// Cursor position and house-select controller. PS/2, IR and held-button
// sources are arbitrated into one command per cycle that moves or selects.
module cursor_ctrl #(
  parameter int H_MAX        = 640,
  parameter int V_MAX        = 480,
  parameter int STEP         = 4,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        ps2_key_pressed_i,
  input  logic [7:0]  ps2_key_data_i,
  input  logic        ir_valid_i,
  input  logic [15:0] ir_in_i,
  input  logic        btn_up_i,
  input  logic        btn_down_i,
  input  logic        btn_left_i,
  input  logic        btn_right_i,
  output logic [9:0]  cursor_x_o,
  output logic [8:0]  cursor_y_o,
  output logic        gryffindor_o,
  output logic        slytherin_o,
  output logic        hufflepuff_o,
  output logic        ravenclaw_o,
  output logic        move_pulse_o,
  output logic [7:0]  drop_cnt_o
);

  typedef enum logic [2:0] {C_UP, C_DOWN, C_LEFT, C_RIGHT, C_G, C_S, C_H, C_R} cmd_e;
  typedef enum logic [1:0] {B_IDLE, B_DELAY, B_REPEAT} bstate_e;

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [10:0] STEP_X = 11'(STEP);
  localparam logic [10:0] X_TOP  = 11'(H_MAX - 1);
  localparam logic [9:0]  STEP_Y = 10'(STEP);
  localparam logic [9:0]  Y_TOP  = 10'(V_MAX - 1);

  logic       ps2_hit, ir_hit, btn_any, btn_grant, ir_drop, grant_valid;
  cmd_e       ps2_cmd, ir_cmd, btn_dir, grant_cmd;
  bstate_e    b_state_q;
  logic       pend_q;
  logic [CNT_W-1:0] cnt_q;
  cmd_e       dir_q;

  logic [9:0] cursor_x_q, cursor_x_d;
  logic [8:0] cursor_y_q, cursor_y_d;
  logic [3:0] house_q, house_d;          // {gryffindor, slytherin, hufflepuff, ravenclaw}
  logic       move_pulse_q;
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic [10:0] x_wide, x_sum;
  logic [9:0]  y_wide, y_sum;

  always_comb begin
    ps2_hit = 1'b0;
    ps2_cmd = C_UP;
    if (ps2_key_pressed_i) begin
      ps2_hit = 1'b1;
      case (ps2_key_data_i)
        8'h75:   ps2_cmd = C_UP;
        8'h72:   ps2_cmd = C_DOWN;
        8'h6B:   ps2_cmd = C_LEFT;
        8'h74:   ps2_cmd = C_RIGHT;
        8'h34:   ps2_cmd = C_G;
        8'h1B:   ps2_cmd = C_S;
        8'h33:   ps2_cmd = C_H;
        8'h2D:   ps2_cmd = C_R;
        default: ps2_hit = 1'b0;
      endcase
    end
  end

  always_comb begin
    ir_hit = 1'b0;
    ir_cmd = C_UP;
    if (ir_valid_i) begin
      ir_hit = 1'b1;
      case (ir_in_i)
        16'h0010: ir_cmd = C_UP;
        16'h0011: ir_cmd = C_DOWN;
        16'h0012: ir_cmd = C_LEFT;
        16'h0013: ir_cmd = C_RIGHT;
        16'h0001: ir_cmd = C_G;
        16'h0002: ir_cmd = C_S;
        16'h0003: ir_cmd = C_H;
        16'h0004: ir_cmd = C_R;
        default:  ir_hit = 1'b0;
      endcase
    end
  end

  assign btn_any = btn_up_i | btn_down_i | btn_left_i | btn_right_i;
  always_comb begin
    if (btn_up_i)        btn_dir = C_UP;
    else if (btn_down_i) btn_dir = C_DOWN;
    else if (btn_left_i) btn_dir = C_LEFT;
    else                 btn_dir = C_RIGHT;
  end

  assign grant_valid = ps2_hit | ir_hit | pend_q;
  assign btn_grant   = pend_q & ~ps2_hit & ~ir_hit;
  assign ir_drop     = ir_hit & ps2_hit;
  assign grant_cmd   = ps2_hit ? ps2_cmd : (ir_hit ? ir_cmd : dir_q);

  // A fresh press or repeat tick re-arms pending even if the old one is granted this cycle.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      b_state_q <= B_IDLE;
      pend_q    <= 1'b0;
      cnt_q     <= '0;
      dir_q     <= C_UP;
    end else if (!btn_any) begin
      b_state_q <= B_IDLE;
      pend_q    <= 1'b0;
      cnt_q     <= '0;
    end else if (b_state_q == B_IDLE || btn_dir != dir_q) begin
      b_state_q <= B_DELAY;
      pend_q    <= 1'b1;
      cnt_q     <= CNT_W'(REPEAT_DELAY - 1);
      dir_q     <= btn_dir;
    end else if (cnt_q == '0) begin
      b_state_q <= B_REPEAT;
      pend_q    <= 1'b1;
      cnt_q     <= CNT_W'(REPEAT_RATE - 1);
    end else begin
      cnt_q <= cnt_q - CNT_W'(1);
      if (btn_grant) pend_q <= 1'b0;
    end
  end

  assign x_wide = {1'b0, cursor_x_q};
  assign y_wide = {1'b0, cursor_y_q};
  assign x_sum  = x_wide + STEP_X;
  assign y_sum  = y_wide + STEP_Y;

  always_comb begin
    cursor_x_d = cursor_x_q;
    cursor_y_d = cursor_y_q;
    house_d    = house_q;
    if (grant_valid) begin
      case (grant_cmd)
        C_UP:    cursor_y_d = (y_wide < STEP_Y) ? 9'd0 : 9'(y_wide - STEP_Y);
        C_DOWN:  cursor_y_d = (y_sum > Y_TOP) ? 9'(Y_TOP) : 9'(y_sum);
        C_LEFT:  cursor_x_d = (x_wide < STEP_X) ? 10'd0 : 10'(x_wide - STEP_X);
        C_RIGHT: cursor_x_d = (x_sum > X_TOP) ? 10'(X_TOP) : 10'(x_sum);
        C_G:     house_d = 4'b1000;
        C_S:     house_d = 4'b0100;
        C_H:     house_d = 4'b0010;
        C_R:     house_d = 4'b0001;
        default: house_d = house_q;
      endcase
    end
    drop_cnt_d = (ir_drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cursor_x_q   <= 10'(H_MAX / 2);
      cursor_y_q   <= 9'(V_MAX / 2);
      house_q      <= 4'b0000;
      move_pulse_q <= 1'b0;
      drop_cnt_q   <= 8'd0;
    end else begin
      cursor_x_q   <= cursor_x_d;
      cursor_y_q   <= cursor_y_d;
      house_q      <= house_d;
      move_pulse_q <= (cursor_x_d != cursor_x_q) || (cursor_y_d != cursor_y_q);
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign cursor_x_o   = cursor_x_q;
  assign cursor_y_o   = cursor_y_q;
  assign gryffindor_o = house_q[3];
  assign slytherin_o  = house_q[2];
  assign hufflepuff_o = house_q[1];
  assign ravenclaw_o  = house_q[0];
  assign move_pulse_o = move_pulse_q;
  assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: doc/cursor_ctrl.md
CURSOR_CTRL -- requirements
Module: cursor_ctrl

Interface
REQ-001 SHALL have parameter H_MAX, default 640, meaning horizontal pixel count; cursor_x range is 0..H_MAX-1.
REQ-002 SHALL have parameter V_MAX, default 480, meaning vertical line count; cursor_y range is 0..V_MAX-1.
REQ-003 SHALL have parameter STEP, default 4, meaning pixels moved per granted move command.
REQ-004 SHALL have parameter REPEAT_DELAY, default 25000000, meaning cycles from a button press to its first auto-repeat.
REQ-005 SHALL have parameter REPEAT_RATE, default 5000000, meaning cycles between later auto-repeats.
REQ-006 SHALL use one clock; reset is synchronous and active-high: clock, input, 1, system clock; all state changes on the rising edge.
REQ-007 reset, input, 1, synchronous active-high reset.
REQ-008 ps2_key_pressed, input, 1, one-cycle strobe; ps2_key_data is valid in that cycle.
REQ-009 ps2_key_data, input, 8, PS/2 set-2 scan code.
REQ-010 ir_valid, input, 1, one-cycle strobe; ir_in is valid in that cycle.
REQ-011 ir_in, input, 16, IR receiver code.
REQ-012 btn_up, btn_down, btn_left, btn_right, input, 1 each, active-high, debounced level.
REQ-013 cursor_x, output, 10, registered cursor column.
REQ-014 cursor_y, output, 9, registered cursor row.
REQ-015 gryffindor, slytherin, hufflepuff, ravenclaw, output, 1 each, registered one-hot house select.
REQ-016 move_pulse, output, 1, one-cycle pulse when cursor_x or cursor_y changes.
REQ-017 drop_cnt, output, 8, saturating count of commands dropped in arbitration.

Function
REQ-018 PS/2 decode SHALL map codes as follows: 0x75 up, 0x72 down, 0x6B left, 0x74 right, 0x34 G, 0x1B S, 0x33 H, 0x2D R. All other codes SHALL be ignored and SHALL NOT count as requests.
REQ-019 IR decode SHALL map ir_in as follows: 0x0010 up, 0x0011 down, 0x0012 left, 0x0013 right, 0x0001 G, 0x0002 S, 0x0003 H, 0x0004 R. All other values SHALL be ignored.
REQ-020 Button requester SHALL be an FSM with states B_IDLE, B_DELAY and B_REPEAT, plus a down-counter and a pending flag.
REQ-021 Held button direction SHALL be resolved by fixed priority: up > down > left > right.
REQ-022 B_IDLE to B_DELAY SHALL occur on any button held. The transition SHALL set pending and load the counter with REPEAT_DELAY-1.
REQ-023 In B_DELAY, when the counter reaches 0, the FSM SHALL set pending, load REPEAT_RATE-1 and go to B_REPEAT. In B_REPEAT, each time the counter reaches 0, it SHALL set pending and reload REPEAT_RATE-1.
REQ-024 No button held SHALL force B_IDLE and clear pending. A change of resolved direction SHALL be treated as a new press: B_DELAY, pending set, counter reloaded.
REQ-025 The arbiter SHALL grant at most one command per cycle with fixed priority PS/2 > IR > button pending.
REQ-026 A losing PS/2 or IR strobe SHALL be dropped and SHALL increment drop_cnt, saturating at 255.
REQ-027 A losing button pending SHALL stay set, is not a drop, and SHALL be granted on the next cycle without a strobe.
REQ-028 Button pending SHALL clear when granted. The repeat counter SHALL keep running while pending waits.
REQ-029 Outputs SHALL update on the clock edge following the granted request; latency is 1 cycle.
REQ-030 Move arithmetic: the result SHALL clamp to the range. Up uses y-STEP, with floor 0. Down uses y+STEP, with ceiling V_MAX-1. Left and right use x the same way with ceiling H_MAX-1. Intermediates SHALL be at least 1 bit wider than the output, with no wrap-around.
REQ-031 move_pulse SHALL be 1 for exactly the cycle where the new position differs from the old one. A clamped no-op move SHALL give move_pulse=0.
REQ-032 A house command SHALL set its output and clear the other three. Selecting the already-selected house SHALL leave the outputs unchanged.

Reset
REQ-033 While reset=1 at an edge: cursor_x=H_MAX/2 (320), cursor_y=V_MAX/2 (240), all house outputs 0, move_pulse=0, drop_cnt=0, FSM B_IDLE, pending 0, counter 0.
REQ-034 Reset asserted mid-repeat or with a pending request SHALL discard it. The first command after reset deassertion SHALL be honored normally.

Verification (bench uses REPEAT_DELAY=8, REPEAT_RATE=3)
REQ-035 Reset, then ps2 strobe 0x74 -> next cycle cursor_x=324, cursor_y=240, move_pulse=1 for 1 cycle.
REQ-036 From x=638, ir 0x0013 -> x=639, pulse=1. Repeat -> x=639, pulse=0. From y=2, ps2 0x75 -> y=0.
REQ-037 Same-cycle ps2 0x72 and ir 0x0001 -> y=244, houses all 0, drop_cnt=1. 256 such collisions -> drop_cnt=255.
REQ-038 Hold btn_left for 20 cycles from x=320: moves at cycles 1, 9, 12, 15, 18 after press, giving final x=300. Release -> B_IDLE.
REQ-039 btn_up held while ps2 0x34 strobes on the press cycle -> cycle 1 gryffindor=1, cycle 2 y=236, drop_cnt=0.
REQ-040 Reset during B_REPEAT -> outputs return to 320/240/0, no move on the cycle after reset deassertion while the button is released.
